// File: rtl/mc_control_fsm.sv
// Multicycle control unit for the 16-bit RISC core: sequences each instruction
// through fetch/decode/execute/memory/writeback and decodes datapath controls.
module mc_control_fsm #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] opcode,
  input  logic       zero_flag,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR,
    S_MEM_RD, S_MEM_WR, S_MEM_WB, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t state_reg;
  logic   is_r_type;
  logic   is_shift;

  assign is_r_type = (opcode[3] == 1'b0) && (opcode[2:0] != 3'b111);
  assign is_shift  = (opcode[3:2] == 2'b00) && (opcode[1:0] != 2'b11);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_RST;
    end else begin
      case (state_reg)
        S_RST:    state_reg <= S_FETCH;
        S_FETCH:  if (mem_ready) state_reg <= S_DECODE;
        S_DECODE: begin
          if (is_r_type)                               state_reg <= S_EXEC_R;
          else if (opcode == OP_ADDI)                  state_reg <= S_EXEC_I;
          else if (opcode == OP_LW || opcode == OP_SW) state_reg <= S_MEM_ADDR;
          else if (opcode == OP_BEQ)                   state_reg <= S_BRANCH;
          else if (opcode == OP_JMP)                   state_reg <= S_JUMP;
          else if (opcode == OP_HALT)                  state_reg <= S_HALT;
          else state_reg <= ILLEGAL_HALT ? S_HALT : S_FETCH;
        end
        S_EXEC_R:   state_reg <= S_ALU_WB;
        S_EXEC_I:   state_reg <= S_ALU_WB;
        S_ALU_WB:   state_reg <= S_FETCH;
        S_MEM_ADDR: state_reg <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) state_reg <= S_MEM_WB;
        S_MEM_WR:   if (mem_ready) state_reg <= S_FETCH;
        S_MEM_WB:   state_reg <= S_FETCH;
        S_BRANCH:   state_reg <= S_FETCH;
        S_JUMP:     state_reg <= S_FETCH;
        S_HALT:     state_reg <= S_HALT;
        default:    state_reg <= S_RST;
      endcase
    end
  end

  // Outputs depend on the live state, so an asynchronous reset drops them at once.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = 3'b011;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal_op = 1'b0;
    halted     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b  = 2'b10;
        illegal_op = (opcode >= 4'hC) && (opcode <= 4'hE);
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = is_shift ? 2'b11 : 2'b00;
        alu_ctrl  = opcode[2:0];
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = is_r_type;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = 3'b100;
        pc_src    = 2'b01;
        pc_en     = zero_flag;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Table-driven bench for mc_control_fsm: per-cycle expected control words are
// queued when a vector is driven and compared when the outputs are sampled.
module tb_mc_control_fsm;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       reg_write, reg_dst, mem_to_reg, illegal_op, halted;
  } outs_t;

  typedef struct {
    string      name;
    logic       rst_n;
    logic [3:0] opcode;
    logic       zero_flag;
    logic       mem_ready;
    outs_t      exp;
  } vec_t;

  typedef struct {
    string name;
    outs_t exp;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n, zero_flag, mem_ready;
  logic [3:0] opcode;

  logic       mem_req0, mem_we0, iord0, ir_write0, pc_en0, alu_src_a0;
  logic       reg_write0, reg_dst0, mem_to_reg0, illegal_op0, halted0;
  logic [1:0] pc_src0, alu_src_b0;
  logic [2:0] alu_ctrl0;
  logic       mem_req1, mem_we1, iord1, ir_write1, pc_en1, alu_src_a1;
  logic       reg_write1, reg_dst1, mem_to_reg1, illegal_op1, halted1;
  logic [1:0] pc_src1, alu_src_b1;
  logic [2:0] alu_ctrl1;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  sb_t  sb_q[$];

  always #5 clk = ~clk;

  mc_control_fsm #(.ILLEGAL_HALT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .mem_req(mem_req0), .mem_we(mem_we0), .iord(iord0),
    .ir_write(ir_write0), .pc_en(pc_en0), .pc_src(pc_src0),
    .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0), .alu_ctrl(alu_ctrl0),
    .reg_write(reg_write0), .reg_dst(reg_dst0), .mem_to_reg(mem_to_reg0),
    .illegal_op(illegal_op0), .halted(halted0)
  );

  mc_control_fsm #(.ILLEGAL_HALT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero_flag(zero_flag),
    .mem_ready(mem_ready), .mem_req(mem_req1), .mem_we(mem_we1), .iord(iord1),
    .ir_write(ir_write1), .pc_en(pc_en1), .pc_src(pc_src1),
    .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .alu_ctrl(alu_ctrl1),
    .reg_write(reg_write1), .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1),
    .illegal_op(illegal_op1), .halted(halted1)
  );

  function automatic outs_t o(input logic mreq, we, io, irw, pce,
                              input logic [1:0] pcs, input logic asa,
                              input logic [1:0] asb, input logic [2:0] ac,
                              input logic rw, rd, m2r, ill, hlt);
    outs_t r;
    r.mem_req = mreq; r.mem_we = we; r.iord = io; r.ir_write = irw;
    r.pc_en = pce; r.pc_src = pcs; r.alu_src_a = asa; r.alu_src_b = asb;
    r.alu_ctrl = ac; r.reg_write = rw; r.reg_dst = rd; r.mem_to_reg = m2r;
    r.illegal_op = ill; r.halted = hlt;
    return r;
  endfunction

  function automatic void add(input string n, input logic r, input logic [3:0] op,
                              input logic zf, input logic mr, input outs_t e);
    vec_t v;
    v.name = n; v.rst_n = r; v.opcode = op; v.zero_flag = zf; v.mem_ready = mr;
    v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic outs_t got0();
    outs_t r;
    r.mem_req = mem_req0; r.mem_we = mem_we0; r.iord = iord0;
    r.ir_write = ir_write0; r.pc_en = pc_en0; r.pc_src = pc_src0;
    r.alu_src_a = alu_src_a0; r.alu_src_b = alu_src_b0; r.alu_ctrl = alu_ctrl0;
    r.reg_write = reg_write0; r.reg_dst = reg_dst0; r.mem_to_reg = mem_to_reg0;
    r.illegal_op = illegal_op0; r.halted = halted0;
    return r;
  endfunction

  task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  initial begin
    outs_t rst_o, fetch_w, fetch_r, dec, dec_ill, ex_add, ex_slr, ex_nand, ex_i;
    outs_t wb_r, wb_i, maddr, mrd, mwr, mwb, br_t, br_n, jmp, hlt;
    outs_t got;
    sb_t   item;

    rst_n = 1'b0; opcode = 4'h0; zero_flag = 1'b0; mem_ready = 1'b0;

    //           mreq we io irw pce pcs  asa asb   ac      rw rd m2r ill hlt
    rst_o   = o(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b011, 0, 0, 0, 0, 0);
    fetch_w = o(1, 0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b011, 0, 0, 0, 0, 0);
    fetch_r = o(1, 0, 0, 1, 1, 2'b00, 0, 2'b01, 3'b011, 0, 0, 0, 0, 0);
    dec     = o(0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 3'b011, 0, 0, 0, 0, 0);
    dec_ill = o(0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 3'b011, 0, 0, 0, 1, 0);
    ex_add  = o(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b011, 0, 0, 0, 0, 0);
    ex_slr  = o(0, 0, 0, 0, 0, 2'b00, 1, 2'b11, 3'b001, 0, 0, 0, 0, 0);
    ex_nand = o(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 3'b110, 0, 0, 0, 0, 0);
    ex_i    = o(0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 3'b011, 0, 0, 0, 0, 0);
    wb_r    = o(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b011, 1, 1, 0, 0, 0);
    wb_i    = o(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b011, 1, 0, 0, 0, 0);
    maddr   = ex_i;
    mrd     = o(1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b011, 0, 0, 0, 0, 0);
    mwr     = o(1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 3'b011, 0, 0, 0, 0, 0);
    mwb     = o(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b011, 1, 0, 1, 0, 0);
    br_t    = o(0, 0, 0, 0, 1, 2'b01, 1, 2'b00, 3'b100, 0, 0, 0, 0, 0);
    br_n    = o(0, 0, 0, 0, 0, 2'b01, 1, 2'b00, 3'b100, 0, 0, 0, 0, 0);
    jmp     = o(0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 3'b011, 0, 0, 0, 0, 0);
    hlt     = o(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b011, 0, 0, 0, 0, 1);

    add("rst.held",    0, 4'h3, 0, 1, rst_o);
    add("rst.release", 1, 4'h3, 0, 1, rst_o);
    add("add.fetch",   1, 4'h3, 0, 1, fetch_r);
    add("add.decode",  1, 4'h3, 0, 1, dec);
    add("add.exec",    1, 4'h3, 0, 1, ex_add);
    add("add.wb",      1, 4'h3, 0, 1, wb_r);
    add("slr.fetch",   1, 4'h1, 0, 1, fetch_r);
    add("slr.decode",  1, 4'h1, 0, 1, dec);
    add("slr.exec",    1, 4'h1, 0, 1, ex_slr);
    add("slr.wb",      1, 4'h1, 0, 1, wb_r);
    add("nand.fetch",  1, 4'h6, 0, 1, fetch_r);
    add("nand.decode", 1, 4'h6, 0, 1, dec);
    add("nand.exec",   1, 4'h6, 0, 1, ex_nand);
    add("nand.wb",     1, 4'h6, 0, 1, wb_r);
    add("addi.fetch",  1, 4'h7, 0, 1, fetch_r);
    add("addi.decode", 1, 4'h7, 0, 1, dec);
    add("addi.exec",   1, 4'h7, 0, 1, ex_i);
    add("addi.wb",     1, 4'h7, 0, 1, wb_i);
    add("lw.fetch",    1, 4'h8, 0, 1, fetch_r);
    add("lw.decode",   1, 4'h8, 0, 1, dec);
    add("lw.addr",     1, 4'h8, 0, 1, maddr);
    add("lw.wait1",    1, 4'h8, 0, 0, mrd);
    add("lw.wait2",    1, 4'h8, 0, 0, mrd);
    add("lw.wait3",    1, 4'h8, 0, 0, mrd);
    add("lw.rd",       1, 4'h8, 0, 1, mrd);
    add("lw.wb",       1, 4'h8, 0, 1, mwb);
    add("sw.fwait",    1, 4'h9, 0, 0, fetch_w);
    add("sw.fetch",    1, 4'h9, 0, 1, fetch_r);
    add("sw.decode",   1, 4'h9, 0, 1, dec);
    add("sw.addr",     1, 4'h9, 0, 1, maddr);
    add("sw.wr",       1, 4'h9, 0, 1, mwr);
    add("beq1.fetch",  1, 4'hA, 0, 1, fetch_r);
    add("beq1.decode", 1, 4'hA, 0, 1, dec);
    add("beq1.taken",  1, 4'hA, 1, 1, br_t);
    add("beq2.fetch",  1, 4'hA, 0, 1, fetch_r);
    add("beq2.decode", 1, 4'hA, 1, 1, dec);
    add("beq2.not",    1, 4'hA, 0, 1, br_n);
    add("jmp.fetch",   1, 4'hB, 0, 1, fetch_r);
    add("jmp.decode",  1, 4'hB, 0, 1, dec);
    add("jmp.jump",    1, 4'hB, 0, 1, jmp);
    add("ill.fetch",   1, 4'hD, 0, 1, fetch_r);
    add("ill.decode",  1, 4'hD, 0, 1, dec_ill);
    add("ill.refetch", 1, 4'h9, 0, 1, fetch_r);
    add("swr.decode",  1, 4'h9, 0, 1, dec);
    add("swr.addr",    1, 4'h9, 0, 1, maddr);
    add("swr.wait",    1, 4'h9, 0, 0, mwr);
    add("swr.abort",   0, 4'h9, 0, 0, rst_o);
    add("swr.rstcyc",  1, 4'h9, 0, 1, rst_o);
    add("swr.fetch",   1, 4'hF, 0, 1, fetch_r);
    add("halt.decode", 1, 4'hF, 0, 1, dec);
    add("halt.h1",     1, 4'hF, 0, 1, hlt);
    add("halt.h2",     1, 4'h3, 0, 1, hlt);
    add("halt.h3",     1, 4'h8, 0, 1, hlt);

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; opcode = vecs[i].opcode;
      zero_flag = vecs[i].zero_flag; mem_ready = vecs[i].mem_ready;
      sb_q.push_back('{vecs[i].name, vecs[i].exp});
      #1;
      got  = got0();
      item = sb_q.pop_front();
      checks++;
      if (got !== item.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", item.name, got, item.exp);
      end else begin
        $display("vec %0d %s ctrl=%h", i, item.name, got);
      end
    end

    // Illegal opcode: non-halting variant refetches, halting variant parks.
    @(negedge clk); rst_n = 1'b0; #1;
    check("ill2.rst_mem_req", {31'd0, mem_req1}, 32'd0);
    @(negedge clk); rst_n = 1'b1; opcode = 4'hD; mem_ready = 1'b1;
    @(negedge clk); #1;
    check("ill2.fetch_ir_write", {31'd0, ir_write1}, 32'd1);
    @(negedge clk); #1;
    check("ill2.pulse0", {31'd0, illegal_op0}, 32'd1);
    check("ill2.pulse1", {31'd0, illegal_op1}, 32'd1);
    mem_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      check($sformatf("ill2.halted1_c%0d", c), {31'd0, halted1}, 32'd1);
      check($sformatf("ill2.memreq1_c%0d", c), {31'd0, mem_req1}, 32'd0);
      if (c == 0) begin
        check("ill2.pulse_end0", {31'd0, illegal_op0}, 32'd0);
        check("ill2.halted0", {31'd0, halted0}, 32'd0);
        check("ill2.refetch0", {31'd0, mem_req0}, 32'd1);
      end
    end
    $display("illegal-op sequence done");

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
